// File: rtl/coord_scanner_pkg.sv
// Shared types for the coordinate scanner and the TransformationUnit stages it feeds.
package coord_scanner_pkg;

  localparam int COORD_W_DEF = 8;

  typedef enum logic [1:0] {
    IDLE,
    SCAN,
    DRAIN,
    DONE
  } scan_state_t;

  typedef struct packed {
    logic [COORD_W_DEF-1:0] x;
    logic [COORD_W_DEF-1:0] y;
  } coord_t;

endpackage

// File: rtl/coord_scanner_if.sv
// Coordinate stream from the scanner to the transform pipeline, with the frame's latched parameters.
interface coord_scanner_if
  import coord_scanner_pkg::*;
#(
  parameter int COORD_W = COORD_W_DEF
);

  logic               coord_valid;
  logic               out_ready;
  logic [COORD_W-1:0] Xcoord;
  logic [COORD_W-1:0] Ycoord;
  logic [COORD_W-1:0] Xcenter;
  logic [COORD_W-1:0] Ycenter;
  logic [COORD_W-1:0] Zoom;
  logic [COORD_W-1:0] Angle;

  modport master (
    output coord_valid, Xcoord, Ycoord, Xcenter, Ycenter, Zoom, Angle,
    input  out_ready
  );

  modport slave (
    input  coord_valid, Xcoord, Ycoord, Xcenter, Ycenter, Zoom, Angle,
    output out_ready
  );

endinterface

// File: rtl/coord_scanner_raster_counter.sv
// Raster-order x/y counter over a width x height region; holds at the last pixel.
module coord_scanner_raster_counter
  import coord_scanner_pkg::*;
#(
  parameter int COORD_W = COORD_W_DEF
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               clear,
  input  logic               advance,
  input  logic [COORD_W-1:0] width,
  input  logic [COORD_W-1:0] height,
  output logic [COORD_W-1:0] x,
  output logic [COORD_W-1:0] y,
  output logic               last
);

  localparam logic [COORD_W-1:0] ONE = COORD_W'(1);

  logic x_end;
  logic y_end;

  assign x_end = (x == width - ONE);
  assign y_end = (y == height - ONE);
  assign last  = x_end && y_end;

  // Step along the row, wrap to the next row at the right edge, stop at the last pixel.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x <= '0;
      y <= '0;
    end else if (clear) begin
      x <= '0;
      y <= '0;
    end else if (advance) begin
      if (!x_end) begin
        x <= x + ONE;
      end else if (!y_end) begin
        x <= '0;
        y <= y + ONE;
      end
    end
  end

endmodule

// File: rtl/coord_scanner.sv
// Walks a latched source region in raster order, then waits out the downstream pipeline before done.
module coord_scanner
  import coord_scanner_pkg::*;
#(
  parameter int COORD_W    = COORD_W_DEF,
  parameter int PIPE_DEPTH = 5
) (
  input  logic               ACLK,
  input  logic               ARESETn,
  input  logic               start,
  input  logic [COORD_W-1:0] src_width,
  input  logic [COORD_W-1:0] src_height,
  input  logic [COORD_W-1:0] Xcenter_in,
  input  logic [COORD_W-1:0] Ycenter_in,
  input  logic [COORD_W-1:0] Zoom_in,
  input  logic [COORD_W-1:0] Angle_in,
  coord_scanner_if.master    bus,
  output logic               busy,
  output logic               done
);

  localparam logic [7:0] DRAIN_INIT = 8'(PIPE_DEPTH - 1);

  scan_state_t        state;
  logic [COORD_W-1:0] width_q;
  logic [COORD_W-1:0] height_q;
  logic [COORD_W-1:0] xc_q;
  logic [COORD_W-1:0] yc_q;
  logic [COORD_W-1:0] zoom_q;
  logic [COORD_W-1:0] angle_q;
  logic [7:0]         drain_cnt;
  logic               valid_q;
  logic               dims_ok;
  logic               cnt_clear;
  logic               cnt_advance;
  logic               last;
  logic [COORD_W-1:0] x;
  logic [COORD_W-1:0] y;

  assign dims_ok     = (src_width != '0) && (src_height != '0);
  assign cnt_clear   = (state == IDLE) && start && dims_ok;
  assign cnt_advance = (state == SCAN) && bus.out_ready && !last;

  coord_scanner_raster_counter #(
    .COORD_W(COORD_W)
  ) u_raster (
    .clk    (ACLK),
    .rst_n  (ARESETn),
    .clear  (cnt_clear),
    .advance(cnt_advance),
    .width  (width_q),
    .height (height_q),
    .x      (x),
    .y      (y),
    .last   (last)
  );

  assign bus.coord_valid = valid_q;
  assign bus.Xcoord      = x;
  assign bus.Ycoord      = y;
  assign bus.Xcenter     = xc_q;
  assign bus.Ycenter     = yc_q;
  assign bus.Zoom        = zoom_q;
  assign bus.Angle       = angle_q;

  // Frame FSM: latch parameters on start, scan until the last transfer, drain, pulse done.
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      state     <= IDLE;
      width_q   <= '0;
      height_q  <= '0;
      xc_q      <= '0;
      yc_q      <= '0;
      zoom_q    <= '0;
      angle_q   <= '0;
      drain_cnt <= '0;
      valid_q   <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start) begin
            xc_q    <= Xcenter_in;
            yc_q    <= Ycenter_in;
            zoom_q  <= Zoom_in;
            angle_q <= Angle_in;
            if (dims_ok) begin
              width_q  <= src_width;
              height_q <= src_height;
              valid_q  <= 1'b1;
              busy     <= 1'b1;
              state    <= SCAN;
            end else begin
              done  <= 1'b1;
              state <= DONE;
            end
          end
        end
        SCAN: begin
          if (bus.out_ready && last) begin
            valid_q   <= 1'b0;
            drain_cnt <= DRAIN_INIT;
            state     <= DRAIN;
          end
        end
        DRAIN: begin
          if (drain_cnt == '0) begin
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= DONE;
          end else begin
            drain_cnt <= drain_cnt - 8'd1;
          end
        end
        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
